// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage (port 0) and the DCT coprocessor (port 1).
// Accept -> issue register -> response register: rsp_valid two edges after the handshake, no ALU back-pressure.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 14,
   parameter int CNTW  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                arb_en,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OPW-1:0]    req_op,
   input  logic [2*WIDTH-1:0]  req_a,
   input  logic [2*WIDTH-1:0]  req_b,
   output logic [1:0]          rsp_valid,
   output logic [WIDTH-1:0]    rsp_result,
   output logic                rsp_zero,
   output logic                rsp_err,
   output logic [OPW-1:0]      alu_op,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic                alu_zero,
   output logic [2*CNTW-1:0]   grant_cnt
);

   localparam logic [OPW-1:0] NOP = {{(OPW-6){1'b0}}, 6'b100001};

   logic             last_grant_q, last_grant_d;
   logic             iss_vld_q, iss_vld_d;
   logic [OPW-1:0]   iss_op_q, iss_op_d;
   logic [WIDTH-1:0] iss_a_q, iss_a_d;
   logic [WIDTH-1:0] iss_b_q, iss_b_d;
   logic             iss_err_q, iss_err_d;
   logic             iss_own_q, iss_own_d;
   logic [1:0]       rsp_vld_q, rsp_vld_d;
   logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CNTW-1:0]  cnt_q [2];
   logic [CNTW-1:0]  cnt_d [2];

   logic             accept;
   logic             gnt_idx;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             op_legal;

   // Ties go to the port that did not win the last accepted transfer.
   always_comb begin
      req_ready = 2'b00;
      if (arb_en) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = last_grant_q ? 2'b01 : 2'b10;
            default: req_ready = 2'b00;
         endcase
      end
   end

   assign accept   = |req_ready;
   assign gnt_idx  = req_ready[1];
   assign sel_op   = gnt_idx ? req_op[2*OPW-1:OPW]   : req_op[OPW-1:0];
   assign sel_a    = gnt_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign sel_b    = gnt_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
   assign op_legal = $onehot(sel_op[OPW-1:5]) && $onehot(sel_op[4:0]);

   always_comb begin
      last_grant_d = last_grant_q;
      iss_vld_d    = 1'b0;
      iss_op_d     = NOP;
      iss_a_d      = iss_a_q;
      iss_b_d      = iss_b_q;
      iss_err_d    = 1'b0;
      iss_own_d    = iss_own_q;
      cnt_d[0]     = cnt_q[0];
      cnt_d[1]     = cnt_q[1];
      if (accept) begin
         last_grant_d = gnt_idx;
         iss_vld_d    = 1'b1;
         iss_op_d     = op_legal ? sel_op : NOP;
         iss_a_d      = sel_a;
         iss_b_d      = sel_b;
         iss_err_d    = ~op_legal;
         iss_own_d    = gnt_idx;
         if (cnt_q[gnt_idx] != {CNTW{1'b1}}) begin
            cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
         end
      end
   end

   // Result fields hold between responses; only the valid pulse clears.
   always_comb begin
      rsp_vld_d  = 2'b00;
      rsp_res_d  = rsp_res_q;
      rsp_zero_d = rsp_zero_q;
      rsp_err_d  = rsp_err_q;
      if (iss_vld_q) begin
         rsp_vld_d[iss_own_q] = 1'b1;
         rsp_res_d            = alu_result;
         rsp_zero_d           = alu_zero;
         rsp_err_d            = iss_err_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         iss_vld_q    <= 1'b0;
         iss_op_q     <= NOP;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         iss_err_q    <= 1'b0;
         iss_own_q    <= 1'b0;
         rsp_vld_q    <= 2'b00;
         rsp_res_q    <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         iss_vld_q    <= iss_vld_d;
         iss_op_q     <= iss_op_d;
         iss_a_q      <= iss_a_d;
         iss_b_q      <= iss_b_d;
         iss_err_q    <= iss_err_d;
         iss_own_q    <= iss_own_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_res_q    <= rsp_res_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         cnt_q[0]     <= cnt_d[0];
         cnt_q[1]     <= cnt_d[1];
      end
   end

   assign alu_op     = iss_op_q;
   assign alu_a      = iss_a_q;
   assign alu_b      = iss_b_q;
   assign rsp_valid  = rsp_vld_q;
   assign rsp_result = rsp_res_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign grant_cnt  = {cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small one-hot ALU stand-in driving alu_result/alu_zero.
module tb_alu_arbiter;

   localparam logic [13:0] ADD0 = 14'h2001;
   localparam logic [13:0] XEQ  = 14'h0410;
   localparam logic [13:0] BAD  = 14'h3001;
   localparam logic [13:0] MUL0 = 14'h0081;
   localparam logic [13:0] NOP  = 14'h0021;

   logic        clk = 1'b0;
   logic        reset;
   logic        arb_en;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [27:0] req_op;
   logic [63:0] req_a, req_b;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;
   logic [13:0] alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic [31:0] grant_cnt;

   int checks = 0;
   int errors = 0;

   alu_arbiter dut (
      .clk(clk), .reset(reset), .arb_en(arb_en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .grant_cnt(grant_cnt)
   );

   always #5 clk = ~clk;

   // ALU stand-in: result group 13 ADD,12 SLL,11 SUB,10 XOR,9 OR,8 AND,7 MUL,6 SRL,5 NOP; flags 4 EQ,3 NE,2 LT,1 GE,0 B==0
   always_comb begin
      alu_result = 32'h0;
      alu_zero   = 1'b0;
      if (alu_op[13]) alu_result = alu_a + alu_b;
      if (alu_op[12]) alu_result = alu_a << alu_b[4:0];
      if (alu_op[11]) alu_result = alu_a - alu_b;
      if (alu_op[10]) alu_result = alu_a ^ alu_b;
      if (alu_op[9])  alu_result = alu_a | alu_b;
      if (alu_op[8])  alu_result = alu_a & alu_b;
      if (alu_op[7])  alu_result = alu_a * alu_b;
      if (alu_op[6])  alu_result = alu_a >> alu_b[4:0];
      if (alu_op[4])  alu_zero = (alu_a == alu_b);
      if (alu_op[3])  alu_zero = (alu_a != alu_b);
      if (alu_op[2])  alu_zero = ($signed(alu_a) < $signed(alu_b));
      if (alu_op[1])  alu_zero = ($signed(alu_a) >= $signed(alu_b));
      if (alu_op[0])  alu_zero = (alu_b == 32'h0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        en;
      logic [1:0]  vld;
      logic [13:0] op0;
      logic [31:0] a0, b0;
      logic [13:0] op1;
      logic [31:0] a1, b1;
      logic [1:0]  x_rdy;
      logic [13:0] x_op;
      logic        chk_a;
      logic [31:0] x_a;
      logic [1:0]  x_rsp;
      logic        chk_d;
      logic [31:0] x_res;
      logic        x_z, x_e;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, input logic [1:0] vld,
                      input logic [13:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [13:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] x_rdy, input logic [13:0] x_op,
                      input logic chk_a, input logic [31:0] x_a, input logic [1:0] x_rsp,
                      input logic chk_d, input logic [31:0] x_res, input logic x_z, input logic x_e);
      vec_t v;
      v.en = en; v.vld = vld; v.op0 = op0; v.a0 = a0; v.b0 = b0;
      v.op1 = op1; v.a1 = a1; v.b1 = b1; v.x_rdy = x_rdy; v.x_op = x_op;
      v.chk_a = chk_a; v.x_a = x_a; v.x_rsp = x_rsp; v.chk_d = chk_d;
      v.x_res = x_res; v.x_z = x_z; v.x_e = x_e;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic en, input logic [1:0] vld,
                        input logic [13:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [13:0] op1, input logic [31:0] a1, input logic [31:0] b1);
      arb_en    = en;
      req_valid = vld;
      req_op    = {op1, op0};
      req_a     = {a1, a0};
      req_b     = {b1, b0};
   endtask

   initial begin
      // Inputs are driven on the falling edge; alu_* shows the previous accept, rsp_* the one before that.
      //   en vld  op0   a0           b0  op1   a1 b1  rdy   alu_op ca alu_a        rsp   cd result       z  e
      add(1, 2'b11, ADD0, 5,           7,  XEQ,  3, 3, 2'b01, NOP,  0, 0,           2'b00, 0, 0,           0, 0);
      add(1, 2'b11, ADD0, 5,           7,  XEQ,  3, 3, 2'b10, ADD0, 1, 5,           2'b00, 0, 0,           0, 0);
      add(1, 2'b11, ADD0, 5,           7,  XEQ,  3, 3, 2'b01, XEQ,  1, 3,           2'b01, 1, 12,          0, 0);
      add(1, 2'b11, ADD0, 5,           7,  XEQ,  3, 3, 2'b10, ADD0, 0, 0,           2'b10, 1, 0,           1, 0);
      add(1, 2'b00, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, XEQ,  0, 0,           2'b01, 1, 12,          0, 0);
      add(1, 2'b00, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b10, 1, 0,           1, 0);
      add(1, 2'b01, ADD0, 5,           7,  XEQ,  3, 3, 2'b01, NOP,  0, 0,           2'b00, 0, 0,           0, 0);
      add(1, 2'b00, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, ADD0, 0, 0,           2'b00, 0, 0,           0, 0);
      add(1, 2'b00, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b01, 1, 12,          0, 0);
      add(1, 2'b10, ADD0, 5,           7,  BAD,  3, 3, 2'b10, NOP,  0, 0,           2'b00, 0, 0,           0, 0);
      add(1, 2'b00, ADD0, 5,           7,  BAD,  3, 3, 2'b00, NOP,  1, 3,           2'b00, 0, 0,           0, 0);
      add(1, 2'b00, ADD0, 5,           7,  BAD,  3, 3, 2'b00, NOP,  0, 0,           2'b10, 1, 0,           0, 1);
      add(1, 2'b00, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b00, 1, 0,           0, 1);
      add(0, 2'b11, ADD0, 5,           7,  XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b00, 0, 0,           0, 0);
      add(1, 2'b01, MUL0, 32'hFFFFFFFD, 4, XEQ,  3, 3, 2'b01, NOP,  0, 0,           2'b00, 0, 0,           0, 0);
      add(0, 2'b11, MUL0, 32'hFFFFFFFD, 4, XEQ,  3, 3, 2'b00, MUL0, 1, 32'hFFFFFFFD, 2'b00, 0, 0,          0, 0);
      add(0, 2'b11, MUL0, 32'hFFFFFFFD, 4, XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b01, 1, 32'hFFFFFFF4, 0, 0);
      add(0, 2'b01, MUL0, 32'hFFFFFFFD, 4, XEQ,  3, 3, 2'b00, NOP,  0, 0,           2'b00, 0, 0,           0, 0);

      reset = 1'b1;
      drive(0, 2'b00, NOP, 0, 0, NOP, 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_rdy",    32'(req_ready), 32'h0);
      chk("reset_rsp",    32'(rsp_valid), 32'h0);
      chk("reset_result", rsp_result, 32'h0);
      chk("reset_alu_op", 32'(alu_op), 32'(NOP));
      chk("reset_cnt",    grant_cnt, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].en, vecs[i].vld, vecs[i].op0, vecs[i].a0, vecs[i].b0,
               vecs[i].op1, vecs[i].a1, vecs[i].b1);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].x_rdy));
         chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].x_op));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].x_rsp));
         if (vecs[i].chk_a) chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].x_a);
         if (vecs[i].chk_d) begin
            chk($sformatf("v%0d_result", i), rsp_result, vecs[i].x_res);
            chk($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].x_z));
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].x_e));
         end
      end

      @(negedge clk);
      drive(1, 2'b00, NOP, 0, 0, NOP, 0, 0);
      #1;
      chk("cnt_port0", 32'(grant_cnt[15:0]), 32'd4);
      chk("cnt_port1", 32'(grant_cnt[31:16]), 32'd3);

      // Reset with an operation sitting in the issue register.
      @(negedge clk);
      drive(1, 2'b01, ADD0, 5, 7, NOP, 0, 0);
      @(negedge clk);
      drive(1, 2'b00, ADD0, 5, 7, NOP, 0, 0);
      #1;
      chk("pre_reset_alu_op", 32'(alu_op), 32'(ADD0));
      #1;
      reset = 1'b1;
      #1;
      chk("async_rsp",    32'(rsp_valid), 32'h0);
      chk("async_result", rsp_result, 32'h0);
      chk("async_alu_op", 32'(alu_op), 32'(NOP));
      chk("async_alu_a",  alu_a, 32'h0);
      chk("async_cnt",    grant_cnt, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_rsp0", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("post_reset_rsp1", 32'(rsp_valid), 32'h0);
      drive(1, 2'b11, ADD0, 5, 7, XEQ, 3, 3);
      #1;
      chk("post_reset_tie", 32'(req_ready), 32'h1);

      // Saturation: fresh reset, then 65534 + 3 back-to-back port 0 transfers.
      @(negedge clk);
      drive(1, 2'b00, ADD0, 5, 7, XEQ, 3, 3);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(negedge clk);
      drive(1, 2'b01, ADD0, 5, 7, XEQ, 3, 3);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      drive(1, 2'b00, ADD0, 5, 7, XEQ, 3, 3);
      #1;
      chk("cnt_fffe", 32'(grant_cnt[15:0]), 32'h0000FFFE);
      drive(1, 2'b01, ADD0, 5, 7, XEQ, 3, 3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      drive(1, 2'b00, ADD0, 5, 7, XEQ, 3, 3);
      #1;
      chk("cnt_sat", 32'(grant_cnt[15:0]), 32'h0000FFFF);
      chk("cnt_p1_idle", 32'(grant_cnt[31:16]), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the core execute stage, port 1 is the JPEG DCT/quantise coprocessor.
- Arbitrates round-robin with a valid/ready handshake per port.
- Registers the winning operands and drives the ALU from that issue register.
- Captures result and branch flag one cycle later and returns them to the winning port as a one-cycle response pulse.
- Sanitises the 14-bit one-hot opcode so the ALU's tri-state result and flag buses never see multiple or zero drivers.

Parameters:
- WIDTH, 32, data width of operands and result; must match the ALU.
- OPW, 14, opcode width; bits 13:5 are the result-select group, bits 4:0 are the flag-select group.
- CNTW, 16, width of the per-port grant statistics counters.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- arb_en  input  1  1 = new grants allowed; 0 = no new grants, in-flight operation still completes.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_ready  output  2  per-port grant/accept; transfer when valid&ready.
- req_op  input  2*OPW  per-port opcode; port i occupies [i*OPW +: OPW].
- req_a  input  2*WIDTH  per-port operand A, packed like req_op.
- req_b  input  2*WIDTH  per-port operand B, packed like req_op.
- rsp_valid  output  2  one-cycle response pulse to port i.
- rsp_result  output  WIDTH  registered ALU result, shared by both ports and qualified by rsp_valid.
- rsp_zero  output  1  registered ALU branch flag.
- rsp_err  output  1  registered; 1 = the accepted opcode was illegal and was replaced.
- alu_op  output  OPW  to ALU aluop.
- alu_a  output  WIDTH  to ALU datain1.
- alu_b  output  WIDTH  to ALU datain2.
- alu_result  input  WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero.
- grant_cnt  output  2*CNTW  per-port saturating count of accepted requests.

Behaviour:
- Reset values:
  - issue register: valid=0, op=NOP, a=0, b=0; NOP = bit5|bit0 = 14'h0021.
  - response register: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - last_grant = 1, so port 0 wins the first tie.
  - grant_cnt = 0.
  - Reset mid-operation discards the in-flight operation; no rsp_valid is produced for it.
- Arbitration is combinational in the request cycle:
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
  - At most one bit of req_ready is set, and only when arb_en=1 and that port's valid=1.
  - One requester: it is granted.
  - Both requesting: grant the port != last_grant.
  - last_grant updates only on an accepted transfer.
- Throughput is one accepted request per cycle. There is no back-pressure from the ALU side; back-to-back transfers from the same port are legal when the other port is idle.
- Opcode check, at accept: legal iff exactly one bit set in [13:5] and exactly one bit set in [4:0].
  - Illegal opcode: the issue register gets NOP and err=1; operands are still registered.
- Issue stage:
  - Edge E accepts a request; during cycle E+1 alu_op/alu_a/alu_b come from the issue register.
  - When the issue register is not valid, alu_op=NOP and alu_a/alu_b hold their last values.
- Response stage:
  - At edge E+1: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=issue.err, rsp_valid[owner]<=1.
  - Latency from handshake edge to rsp_valid high is exactly 2 edges.
  - rsp_valid stays high for exactly one cycle per accepted request; responses return in accept order.
  - rsp_result/rsp_zero/rsp_err hold their value until the next response.
- arb_en falling while an operation is in the issue stage: that operation still responds normally.
- grant_cnt[i] increments on each accepted transfer from port i and saturates at 2^CNTW-1 (no wrap).
- Both ports always drive their own fields; an unused port ties req_valid low.

Test Plan:
- Port 0 only: op=ADD|BBUS0 (14'h2001), a=5, b=7 -> req_ready=01 in the same cycle; rsp_valid=01 two edges later; rsp_result=12, rsp_zero=0, rsp_err=0.
- Both ports valid for 4 cycles, port 1 op=XOR|EQ (14'h0410), a=b=3 -> grants alternate 01,10,01,10; responses in the same order; port 1 responses show result=0, zero=1.
- Illegal op 14'h3001 (ADD|SLL) on port 1 -> alu_op=14'h0021 in the issue cycle; rsp_result=0, rsp_zero=0, rsp_err=1.
- arb_en dropped in the cycle after accepting a port 0 MUL (14'h0081), a=-3, b=4 -> that response still arrives with result=-12; no further req_ready while arb_en=0.
- Reset asserted with an operation in the issue stage -> no rsp_valid for it; all outputs return to reset values asynchronously; the first grant after release goes to port 0 on a tie.
- Force grant_cnt[0] to 16'hFFFE, then make 3 port 0 transfers -> the counter stops at 16'hFFFF.
